// File: rtl/sm_trace_buffer.sv
// Instruction trace buffer: records {pc, instr, data, cycle} for each CPU step
// into a circular store, with optional start trigger, timeout and pc self-loop
// (halt) detection. Entries are popped oldest-first through a registered port.
module sm_trace_buffer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WRAP     = 1,
  parameter int unsigned TIMEOUT  = 160,
  parameter int unsigned HALT_CNT = 4,
  parameter int unsigned TRIG_EN  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [31:0]                pc,
  input  logic [31:0]                instr,
  input  logic [DATA_W-1:0]          data,
  input  logic [31:0]                trig_pc,
  input  logic                       clear,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [31:0]                rd_pc,
  output logic [31:0]                rd_instr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [31:0]                rd_cycle,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state,
  output logic                       overflow,
  output logic                       timeout,
  output logic                       halted
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDone    = 2'd2
  } state_e;

  localparam state_e StReset = (TRIG_EN != 0) ? StIdle : StCapture;

  // Trace storage
  logic [31:0]       mem_pc    [DEPTH];
  logic [31:0]       mem_instr [DEPTH];
  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [31:0]       mem_cyc   [DEPTH];

  // Control state
  state_e            state_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [31:0]       cyc_q;
  logic [31:0]       last_pc_q;
  logic              last_vld_q;
  logic [31:0]       rep_cnt_q;
  logic              overflow_q;
  logic              timeout_q;
  logic              halted_q;

  // Read port registers
  logic              rd_valid_q;
  logic [31:0]       rd_pc_q;
  logic [31:0]       rd_instr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [31:0]       rd_cycle_q;

  // Decoded per-cycle events
  logic        full;
  logic        pop;
  logic        sample;
  logic        blocked;
  logic        drop;
  logic        wr;
  logic        ovwr;
  logic        is_repeat;
  logic [31:0] rep_next;
  logic        hit_halt;
  logic        hit_tmo;
  logic        restart;

  // Decode capture/pop events for this cycle
  always_comb begin
    restart   = !rst_n || clear;
    full      = (count_q == CntW'(DEPTH));
    pop       = rd_en && (count_q != '0);
    sample    = en && ((state_q == StCapture) ||
                       ((state_q == StIdle) && (pc == trig_pc)));
    // A simultaneous pop frees the oldest slot, so a full buffer can still accept
    blocked   = full && !pop;
    drop      = sample && blocked && (WRAP == 0);
    wr        = sample && !drop;
    ovwr      = wr && blocked;
    is_repeat = last_vld_q && (pc == last_pc_q);
    rep_next  = is_repeat ? (rep_cnt_q + 32'd1) : 32'd0;
    hit_halt  = wr && (HALT_CNT != 0) && is_repeat && (rep_next == HALT_CNT);
    hit_tmo   = wr && (TIMEOUT != 0) && (cyc_q == TIMEOUT - 1);
  end

  // FSM, pointers, occupancy, capture counter and sticky flags
  always_ff @(posedge clk) begin
    if (restart) begin
      state_q    <= StReset;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
      rep_cnt_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        cyc_q      <= cyc_q + 32'd1;
        last_pc_q  <= pc;
        last_vld_q <= 1'b1;
        rep_cnt_q  <= rep_next;
      end

      // Overwrite and pop both consume the oldest entry; never advance twice
      if (ovwr || pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      if (wr && !blocked && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !wr) begin
        count_q <= count_q - 1'b1;
      end

      if (ovwr || drop) begin
        overflow_q <= 1'b1;
      end
      if (hit_tmo) begin
        timeout_q <= 1'b1;
      end
      if (hit_halt) begin
        halted_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (hit_tmo || hit_halt) begin
            state_q <= StDone;
          end else if (wr) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          if (drop || hit_tmo || hit_halt) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StReset;
        end
      endcase
    end
  end

  // Trace storage write; contents are not reset, occupancy tracks validity
  always_ff @(posedge clk) begin
    if (!restart && wr) begin
      mem_pc[wr_ptr_q]    <= pc;
      mem_instr[wr_ptr_q] <= instr;
      mem_data[wr_ptr_q]  <= data;
      mem_cyc[wr_ptr_q]   <= cyc_q;
    end
  end

  // Registered pop port; reads the pre-write value when overwriting the oldest slot
  always_ff @(posedge clk) begin
    if (restart) begin
      rd_valid_q <= 1'b0;
      rd_pc_q    <= '0;
      rd_instr_q <= '0;
      rd_data_q  <= '0;
      rd_cycle_q <= '0;
    end else begin
      rd_valid_q <= pop;
      if (pop) begin
        rd_pc_q    <= mem_pc[rd_ptr_q];
        rd_instr_q <= mem_instr[rd_ptr_q];
        rd_data_q  <= mem_data[rd_ptr_q];
        rd_cycle_q <= mem_cyc[rd_ptr_q];
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_pc    = rd_pc_q;
  assign rd_instr = rd_instr_q;
  assign rd_data  = rd_data_q;
  assign rd_cycle = rd_cycle_q;
  assign count    = count_q;
  assign state    = state_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Directed bench for sm_trace_buffer: four instances cover wrap, no-wrap,
// timeout/halt and trigger configurations. Inputs change 1 time unit after the
// rising edge; outputs are checked at the same point, reflecting that edge.
module tb_sm_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] data;
  logic [31:0] trig_pc;
  logic [3:0]  en_v;
  logic [3:0]  rd_en_v;
  logic [3:0]  rv;
  logic [3:0]  ovf;
  logic [3:0]  tmo;
  logic [3:0]  hlt;
  logic [1:0]  st   [4];
  logic [31:0] rpc  [4];
  logic [31:0] rins [4];
  logic [31:0] rdat [4];
  logic [31:0] rcyc [4];
  logic [2:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [4:0]  cnt_c;
  logic [4:0]  cnt_d;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // A: small wrapping buffer
  sm_trace_buffer #(.DEPTH(4), .DATA_W(32), .WRAP(1), .TIMEOUT(0), .HALT_CNT(0), .TRIG_EN(0))
  u_a (.clk(clk), .rst_n(rst_n), .en(en_v[0]), .pc(pc), .instr(instr), .data(data),
       .trig_pc(trig_pc), .clear(clear), .rd_en(rd_en_v[0]), .rd_valid(rv[0]), .rd_pc(rpc[0]),
       .rd_instr(rins[0]), .rd_data(rdat[0]), .rd_cycle(rcyc[0]), .count(cnt_a), .state(st[0]),
       .overflow(ovf[0]), .timeout(tmo[0]), .halted(hlt[0]));

  // B: small stop-when-full buffer
  sm_trace_buffer #(.DEPTH(4), .DATA_W(32), .WRAP(0), .TIMEOUT(0), .HALT_CNT(0), .TRIG_EN(0))
  u_b (.clk(clk), .rst_n(rst_n), .en(en_v[1]), .pc(pc), .instr(instr), .data(data),
       .trig_pc(trig_pc), .clear(clear), .rd_en(rd_en_v[1]), .rd_valid(rv[1]), .rd_pc(rpc[1]),
       .rd_instr(rins[1]), .rd_data(rdat[1]), .rd_cycle(rcyc[1]), .count(cnt_b), .state(st[1]),
       .overflow(ovf[1]), .timeout(tmo[1]), .halted(hlt[1]));

  // C: timeout and halt detection
  sm_trace_buffer #(.DEPTH(16), .DATA_W(32), .WRAP(1), .TIMEOUT(10), .HALT_CNT(4), .TRIG_EN(0))
  u_c (.clk(clk), .rst_n(rst_n), .en(en_v[2]), .pc(pc), .instr(instr), .data(data),
       .trig_pc(trig_pc), .clear(clear), .rd_en(rd_en_v[2]), .rd_valid(rv[2]), .rd_pc(rpc[2]),
       .rd_instr(rins[2]), .rd_data(rdat[2]), .rd_cycle(rcyc[2]), .count(cnt_c), .state(st[2]),
       .overflow(ovf[2]), .timeout(tmo[2]), .halted(hlt[2]));

  // D: start trigger
  sm_trace_buffer #(.DEPTH(16), .DATA_W(32), .WRAP(1), .TIMEOUT(0), .HALT_CNT(0), .TRIG_EN(1))
  u_d (.clk(clk), .rst_n(rst_n), .en(en_v[3]), .pc(pc), .instr(instr), .data(data),
       .trig_pc(trig_pc), .clear(clear), .rd_en(rd_en_v[3]), .rd_valid(rv[3]), .rd_pc(rpc[3]),
       .rd_instr(rins[3]), .rd_data(rdat[3]), .rd_cycle(rcyc[3]), .count(cnt_d), .state(st[3]),
       .overflow(ovf[3]), .timeout(tmo[3]), .halted(hlt[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input logic [31:0] p);
    pc    = p;
    instr = p ^ 32'hA5A5_0000;
    data  = p + 32'd1000;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    if (cnt_a !== 3'd0) begin $display("FAIL reset_count_a got %0d want 0", cnt_a); n_bad++; end
    n_cmp++;
    if (cnt_d !== 5'd0) begin $display("FAIL reset_count_d got %0d want 0", cnt_d); n_bad++; end
    n_cmp++;
    if (st[0] !== 2'd1) begin $display("FAIL reset_state_a got %0d want 1", st[0]); n_bad++; end
    n_cmp++;
    if (st[3] !== 2'd0) begin $display("FAIL reset_state_d got %0d want 0", st[3]); n_bad++; end
    n_cmp++;
    if ({rv, ovf, tmo, hlt} !== 16'h0) begin
      $display("FAIL reset_flags got %h want 0", {rv, ovf, tmo, hlt}); n_bad++;
    end
    n_cmp++;
    if (rpc[0] !== 32'd0 || rcyc[0] !== 32'd0) begin
      $display("FAIL reset_rd got %h/%h want 0/0", rpc[0], rcyc[0]); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_wrap();
    do_clear();
    en_v[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_sample(32'(4 * i));
      step();
    end
    en_v[0] = 1'b0;
    if (cnt_a !== 3'd4) begin $display("FAIL wrap_count got %0d want 4", cnt_a); n_bad++; end
    n_cmp++;
    if (ovf[0] !== 1'b1) begin $display("FAIL wrap_overflow got %0b want 1", ovf[0]); n_bad++; end
    n_cmp++;
    rd_en_v[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (rv[0] !== 1'b1 || rpc[0] !== 32'(8 + 4 * k) || rcyc[0] !== 32'(2 + k)) begin
        $display("FAIL wrap_pop%0d got v=%0b pc=%h cyc=%0d want 1/%h/%0d",
                 k, rv[0], rpc[0], rcyc[0], 8 + 4 * k, 2 + k);
        n_bad++;
      end
      n_cmp++;
      if (k == 0 && (rins[0] !== 32'hA5A5_0008 || rdat[0] !== 32'd1008)) begin
        $display("FAIL wrap_pop_payload got %h/%h want a5a50008/%h", rins[0], rdat[0], 1008);
        n_bad++;
      end
      if (k == 0) n_cmp++;
    end
    rd_en_v[0] = 1'b0;
    step();
    if (cnt_a !== 3'd0 || rv[0] !== 1'b0 || rpc[0] !== 32'd20) begin
      $display("FAIL wrap_drain got cnt=%0d v=%0b pc=%h want 0/0/14", cnt_a, rv[0], rpc[0]);
      n_bad++;
    end
    n_cmp++;
    rd_en_v[0] = 1'b1;
    step();
    rd_en_v[0] = 1'b0;
    if (rv[0] !== 1'b0 || cnt_a !== 3'd0 || rpc[0] !== 32'd20) begin
      $display("FAIL pop_empty got v=%0b cnt=%0d pc=%h want 0/0/14", rv[0], cnt_a, rpc[0]);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    do_clear();
    en_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_sample(32'h100 + 32'(4 * i));
      step();
    end
    set_sample(32'h110);
    rd_en_v[0] = 1'b1;
    step();
    en_v[0] = 1'b0;
    if (rv[0] !== 1'b1 || rpc[0] !== 32'h100 || cnt_a !== 3'd4) begin
      $display("FAIL pop_during_overwrite got v=%0b pc=%h cnt=%0d want 1/100/4",
               rv[0], rpc[0], cnt_a);
      n_bad++;
    end
    n_cmp++;
    step();
    rd_en_v[0] = 1'b0;
    if (rpc[0] !== 32'h104 || rcyc[0] !== 32'd1 || cnt_a !== 3'd3) begin
      $display("FAIL pop_after_overwrite got pc=%h cyc=%0d cnt=%0d want 104/1/3",
               rpc[0], rcyc[0], cnt_a);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_clear();
    // A holds 3 entries; one more fills it, the next overwrites
    en_v[0] = 1'b1;
    set_sample(32'h200);
    step();
    set_sample(32'h204);
    step();
    if (ovf[0] !== 1'b1) begin $display("FAIL clear_pre_ovf got %0b want 1", ovf[0]); n_bad++; end
    n_cmp++;
    rd_en_v[0] = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    rd_en_v[0] = 1'b0;
    en_v[0] = 1'b0;
    if (rv[0] !== 1'b0 || cnt_a !== 3'd0 || ovf[0] !== 1'b0 || st[0] !== 2'd1 ||
        rpc[0] !== 32'd0) begin
      $display("FAIL clear_mid_capture got v=%0b cnt=%0d ovf=%0b st=%0d pc=%h want 0/0/0/1/0",
               rv[0], cnt_a, ovf[0], st[0], rpc[0]);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_nowrap();
    do_clear();
    en_v[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_sample(32'h40 + 32'(4 * i));
      step();
    end
    en_v[1] = 1'b0;
    if (cnt_b !== 3'd4 || ovf[1] !== 1'b1 || st[1] !== 2'd2) begin
      $display("FAIL nowrap_full got cnt=%0d ovf=%0b st=%0d want 4/1/2", cnt_b, ovf[1], st[1]);
      n_bad++;
    end
    n_cmp++;
    rd_en_v[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (rv[1] !== 1'b1 || rpc[1] !== 32'h40 + 32'(4 * k) || rcyc[1] !== 32'(k)) begin
        $display("FAIL nowrap_pop%0d got pc=%h cyc=%0d want %h/%0d",
                 k, rpc[1], rcyc[1], 32'h40 + 32'(4 * k), k);
        n_bad++;
      end
      n_cmp++;
    end
    rd_en_v[1] = 1'b0;
  endtask

  task automatic test_timeout();
    do_clear();
    en_v[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_sample(32'(4 * i));
      step();
      if (i == 8 && (st[2] !== 2'd1 || tmo[2] !== 1'b0)) begin
        $display("FAIL timeout_early got st=%0d tmo=%0b want 1/0", st[2], tmo[2]);
        n_bad++;
      end
      if (i == 8) n_cmp++;
    end
    if (st[2] !== 2'd2 || tmo[2] !== 1'b1 || hlt[2] !== 1'b0 || cnt_c !== 5'd10) begin
      $display("FAIL timeout_hit got st=%0d tmo=%0b hlt=%0b cnt=%0d want 2/1/0/10",
               st[2], tmo[2], hlt[2], cnt_c);
      n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      set_sample(32'h1000);
      step();
    end
    en_v[2] = 1'b0;
    if (cnt_c !== 5'd10 || st[2] !== 2'd2) begin
      $display("FAIL timeout_frozen got cnt=%0d st=%0d want 10/2", cnt_c, st[2]);
      n_bad++;
    end
    n_cmp++;
    rd_en_v[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rpc[2] !== 32'(4 * k) || rcyc[2] !== 32'(k)) begin
        $display("FAIL timeout_pop%0d got pc=%h cyc=%0d want %h/%0d", k, rpc[2], rcyc[2], 4 * k, k);
        n_bad++;
      end
      n_cmp++;
    end
    rd_en_v[2] = 1'b0;
  endtask

  task automatic test_halt();
    logic [31:0] seq [6];
    seq = '{32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC};
    do_clear();
    en_v[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_sample(seq[i]);
      step();
      if (i == 4 && (hlt[2] !== 1'b0 || st[2] !== 2'd1)) begin
        $display("FAIL halt_early got hlt=%0b st=%0d want 0/1", hlt[2], st[2]);
        n_bad++;
      end
      if (i == 4) n_cmp++;
    end
    en_v[2] = 1'b0;
    if (hlt[2] !== 1'b1 || st[2] !== 2'd2 || cnt_c !== 5'd6 || tmo[2] !== 1'b0) begin
      $display("FAIL halt_hit got hlt=%0b st=%0d cnt=%0d tmo=%0b want 1/2/6/0",
               hlt[2], st[2], cnt_c, tmo[2]);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_halt_and_timeout();
    logic [31:0] seq [10];
    seq = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd20, 32'd20, 32'd20, 32'd20};
    do_clear();
    en_v[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_sample(seq[i]);
      step();
    end
    en_v[2] = 1'b0;
    if (hlt[2] !== 1'b1 || tmo[2] !== 1'b1 || st[2] !== 2'd2 || cnt_c !== 5'd10) begin
      $display("FAIL halt_and_timeout got hlt=%0b tmo=%0b st=%0d cnt=%0d want 1/1/2/10",
               hlt[2], tmo[2], st[2], cnt_c);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_trigger();
    trig_pc = 32'h10;
    do_clear();
    if (st[3] !== 2'd0) begin $display("FAIL trig_idle got %0d want 0", st[3]); n_bad++; end
    n_cmp++;
    en_v[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_sample(32'(4 * i));
      step();
      if (st[3] !== 2'd0 || cnt_d !== 5'd0) begin
        $display("FAIL trig_wait%0d got st=%0d cnt=%0d want 0/0", i, st[3], cnt_d);
        n_bad++;
      end
      n_cmp++;
    end
    set_sample(32'h10);
    step();
    if (st[3] !== 2'd1 || cnt_d !== 5'd1) begin
      $display("FAIL trig_fire got st=%0d cnt=%0d want 1/1", st[3], cnt_d);
      n_bad++;
    end
    n_cmp++;
    set_sample(32'h14);
    step();
    en_v[3] = 1'b0;
    rd_en_v[3] = 1'b1;
    step();
    rd_en_v[3] = 1'b0;
    if (rv[3] !== 1'b1 || rpc[3] !== 32'h10 || rcyc[3] !== 32'd0 || cnt_d !== 5'd1) begin
      $display("FAIL trig_pop got v=%0b pc=%h cyc=%0d cnt=%0d want 1/10/0/1",
               rv[3], rpc[3], rcyc[3], cnt_d);
      n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    rst_n   = 1'b0;
    clear   = 1'b0;
    en_v    = '0;
    rd_en_v = '0;
    trig_pc = 32'h10;
    set_sample(32'd0);
    test_reset();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_nowrap();
    test_timeout();
    test_halt();
    test_halt_and_timeout();
    test_trigger();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
